// File: rtl/systolic_array_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_array_ctrl
//   Job sequencer for a 4x4 systolic array. A job of K operand beats is fed
//   through diagonal skew lines (row i / column j delayed i / j cycles). The
//   16 bottom-edge results are collected into a buffer and returned as four
//   row beats on a valid/ready stream.
//
// Optional feature macro: SA_CTRL_PERF_EN
//   When defined, adds output perf_cycles (cycles from cmd accept to the final
//   result handshake of the last completed job, saturating).
//
// Ports:
//   ctrl_clk, ctrl_rst_n                 clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_len          job request (ready only in IDLE)
//   in_valid/in_ready/in_a/in_b          operand beats (ready only in FEED)
//   array_en_left/array_data_left        skewed row inputs to the array
//   array_en_up/array_data_up            skewed column inputs to the array
//   array_en_down/array_data_down        bottom-edge results from the array
//   res_valid/res_ready/res_data/res_last result rows, res_last on row 3
//   busy                                 state != IDLE
//   err_timeout                          last job timed out (sticky)
// -----------------------------------------------------------------------------
module systolic_array_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    ctrl_clk,
  input  logic                    ctrl_rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*DATA_WIDTH-1:0] in_a,
  input  logic [4*DATA_WIDTH-1:0] in_b,
  output logic [3:0]              array_en_left,
  output logic [4*DATA_WIDTH-1:0] array_data_left,
  output logic [3:0]              array_en_up,
  output logic [4*DATA_WIDTH-1:0] array_data_up,
  input  logic [3:0]              array_en_down,
  input  logic [4*DATA_WIDTH-1:0] array_data_down,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [4*DATA_WIDTH-1:0] res_data,
  output logic                    res_last,
  output logic                    busy,
  output logic                    err_timeout
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);

  localparam int DW     = DATA_WIDTH;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  beat_cnt_r;
  logic [WCNT_W-1:0] wait_cnt_r;
  logic [1:0]        row_r;
  logic [2:0]        col_cnt_r [4];
  logic [DW-1:0]     res_buf_r [4][4];

  logic cmd_fire_s, in_fire_s, res_fire_s, all_done_s, wait_expired_s, collect_s;

  assign cmd_fire_s     = cmd_valid & (state_r == S_IDLE);
  assign in_fire_s      = in_valid & (state_r == S_FEED);
  assign res_fire_s     = res_ready & (state_r == S_OUT);
  assign collect_s      = (state_r == S_FEED) | (state_r == S_WAIT);
  assign all_done_s     = (col_cnt_r[0] == 3'd4) & (col_cnt_r[1] == 3'd4) &
                          (col_cnt_r[2] == 3'd4) & (col_cnt_r[3] == 3'd4);
  // The WAIT cycle in which the counter holds TIMEOUT-1 is the last one allowed.
  assign wait_expired_s = (wait_cnt_r == WCNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) state_r <= S_IDLE;
    else             state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (cmd_fire_s) state_s = (cmd_len == '0) ? S_OUT : S_FEED;
        else            state_s = S_IDLE;
      end
      S_FEED: begin
        if (in_fire_s && ((beat_cnt_r + LEN_W'(1)) == len_r)) state_s = S_WAIT;
        else                                                  state_s = S_FEED;
      end
      S_WAIT: begin
        if (all_done_s || wait_expired_s) state_s = S_OUT;
        else                              state_s = S_WAIT;
      end
      S_OUT: begin
        if (res_fire_s && (row_r == 2'd3)) state_s = S_IDLE;
        else                               state_s = S_OUT;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // Job length, beat/wait/row counters and the sticky timeout flag.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      len_r       <= '0;
      beat_cnt_r  <= '0;
      wait_cnt_r  <= '0;
      row_r       <= 2'd0;
      err_timeout <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (cmd_fire_s) begin
            len_r       <= cmd_len;
            beat_cnt_r  <= '0;
            wait_cnt_r  <= '0;
            row_r       <= 2'd0;
            err_timeout <= 1'b0;
          end
        end
        S_FEED: begin
          if (in_fire_s) beat_cnt_r <= beat_cnt_r + LEN_W'(1);
        end
        S_WAIT: begin
          wait_cnt_r <= wait_cnt_r + WCNT_W'(1);
          // Completion wins over the timeout if both land in the same cycle.
          if (wait_expired_s && !all_done_s) err_timeout <= 1'b1;
        end
        S_OUT: begin
          if (res_fire_s) row_r <= row_r + 2'd1;
        end
        default: begin
          row_r <= 2'd0;
        end
      endcase
    end
  end

  // Bottom-edge collection: each column fills buffer rows 0..3 in arrival order.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      for (int j = 0; j < 4; j++) begin
        col_cnt_r[j] <= 3'd0;
        for (int r = 0; r < 4; r++) res_buf_r[r][j] <= '0;
      end
    end else if (cmd_fire_s) begin
      for (int j = 0; j < 4; j++) begin
        col_cnt_r[j] <= 3'd0;
        for (int r = 0; r < 4; r++) res_buf_r[r][j] <= '0;
      end
    end else if (collect_s) begin
      for (int j = 0; j < 4; j++) begin
        if (array_en_down[j] && (col_cnt_r[j] != 3'd4)) begin
          res_buf_r[col_cnt_r[j][1:0]][j] <= array_data_down[j*DW +: DW];
          col_cnt_r[j]                    <= col_cnt_r[j] + 3'd1;
        end
      end
    end
  end

  // Skew lines: lane k is a (k+1)-stage chain; bubbles shift in when no beat is accepted.
  for (genvar k = 0; k < 4; k++) begin : g_skew
    logic [k:0]    left_en_r, up_en_r;
    logic [DW-1:0] left_d_r [k+1];
    logic [DW-1:0] up_d_r   [k+1];

    // Shift register chain for row k and column k.
    always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
      if (!ctrl_rst_n) begin
        left_en_r <= '0;
        up_en_r   <= '0;
        for (int s = 0; s <= k; s++) begin
          left_d_r[s] <= '0;
          up_d_r[s]   <= '0;
        end
      end else begin
        left_en_r[0] <= in_fire_s;
        up_en_r[0]   <= in_fire_s;
        left_d_r[0]  <= in_fire_s ? in_a[k*DW +: DW] : '0;
        up_d_r[0]    <= in_fire_s ? in_b[k*DW +: DW] : '0;
        for (int s = 1; s <= k; s++) begin
          left_en_r[s] <= left_en_r[s-1];
          up_en_r[s]   <= up_en_r[s-1];
          left_d_r[s]  <= left_d_r[s-1];
          up_d_r[s]    <= up_d_r[s-1];
        end
      end
    end

    assign array_en_left[k]              = left_en_r[k];
    assign array_en_up[k]                = up_en_r[k];
    assign array_data_left[k*DW +: DW]   = left_d_r[k];
    assign array_data_up[k*DW +: DW]     = up_d_r[k];
  end

  // Output decode from the state register and the result buffer.
  always_comb begin
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    res_last  = 1'b0;
    busy      = 1'b1;
    res_data  = '0;
    case (state_r)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_FEED: in_ready = 1'b1;
      S_WAIT: busy = 1'b1;
      S_OUT: begin
        res_valid = 1'b1;
        res_last  = (row_r == 2'd3);
        for (int j = 0; j < 4; j++) res_data[j*DW +: DW] = res_buf_r[row_r][j];
      end
      default: busy = 1'b0;
    endcase
  end

`ifdef SA_CTRL_PERF_EN
  logic [31:0] run_cnt_r;

  // Job latency counter; captured into perf_cycles on the final result handshake.
  always_ff @(posedge ctrl_clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      run_cnt_r   <= 32'd0;
      perf_cycles <= 32'd0;
    end else begin
      if (cmd_fire_s)                                            run_cnt_r <= 32'd0;
      else if ((state_r != S_IDLE) && (run_cnt_r != 32'hFFFF_FFFF)) run_cnt_r <= run_cnt_r + 32'd1;
      else                                                       run_cnt_r <= run_cnt_r;
      if (res_fire_s && (row_r == 2'd3))
        perf_cycles <= (run_cnt_r == 32'hFFFF_FFFF) ? run_cnt_r : run_cnt_r + 32'd1;
      else
        perf_cycles <= perf_cycles;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_array_ctrl.sv
module tb_systolic_array_ctrl;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready;
  logic [LW-1:0] cmd_len;
  logic          in_valid, in_ready;
  logic [127:0]  in_a, in_b;
  logic [3:0]    array_en_left, array_en_up, array_en_down;
  logic [127:0]  array_data_left, array_data_up, array_data_down;
  logic          res_valid, res_ready, res_last, busy, err_timeout;
  logic [127:0]  res_data;

  always #5 clk = ~clk;

  systolic_array_ctrl #(.DATA_WIDTH(DW), .LEN_W(LW), .TIMEOUT(64)) dut (
    .ctrl_clk(clk), .ctrl_rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .array_en_left(array_en_left), .array_data_left(array_data_left),
    .array_en_up(array_en_up), .array_data_up(array_data_up),
    .array_en_down(array_en_down), .array_data_down(array_data_down),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .err_timeout(err_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: accepted-beat history per cycle and expected result matrix.
  bit           acc_en [4096];
  logic [127:0] acc_a  [4096];
  logic [127:0] acc_b  [4096];
  int           cyc = 0;
  bit           push_now = 1'b0;
  logic [31:0]  exp_buf [4][4];
  int           col_cnt [4];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_hist();
    for (int k = 0; k < 4096; k++) acc_en[k] = 1'b0;
  endtask

  // Advance one clock; then check every skew lane against the beat history.
  task automatic step();
    logic [3:0]   el, eu;
    logic [127:0] dl, du;
    int           src;
    acc_en[cyc & 4095] = push_now;
    acc_a[cyc & 4095]  = in_a;
    acc_b[cyc & 4095]  = in_b;
    @(posedge clk);
    #1;
    cyc++;
    el = 4'd0; eu = 4'd0; dl = '0; du = '0;
    for (int i = 0; i < 4; i++) begin
      src = cyc - 1 - i;
      if (src >= 0 && acc_en[src & 4095]) begin
        el[i] = 1'b1;
        eu[i] = 1'b1;
        dl[i*DW +: DW] = acc_a[src & 4095][i*DW +: DW];
        du[i*DW +: DW] = acc_b[src & 4095][i*DW +: DW];
      end
    end
    check_val("en_left",   128'(array_en_left), 128'(el));
    check_val("data_left", array_data_left, dl);
    check_val("en_up",     128'(array_en_up), 128'(eu));
    check_val("data_up",   array_data_up, du);
  endtask

  // Drive one cycle of bottom-edge pulses; the model keeps the first four per column.
  task automatic pulse(input logic [3:0] en);
    logic [31:0] v;
    array_en_down = en;
    array_data_down = '0;
    for (int j = 0; j < 4; j++) begin
      if (en[j]) begin
        v = $urandom;
        array_data_down[j*DW +: DW] = v;
        if (col_cnt[j] < 4) begin
          exp_buf[col_cnt[j]][j] = v;
          col_cnt[j]++;
        end
      end
    end
  endtask

  // mode 0: random complete pulses with cmd/in noise; 1: fixed pattern with backpressure; 2: timeout.
  task automatic run_job(input int len, input int bubble_at, input int mode, input bit fixed);
    int           since, n, stall;
    bit           tmo, done;
    logic [127:0] er;
    logic [3:0]   en;
    int           offs [4];
    for (int r = 0; r < 4; r++) for (int j = 0; j < 4; j++) exp_buf[r][j] = 32'd0;
    for (int j = 0; j < 4; j++) col_cnt[j] = 0;
    check_val("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1;
    cmd_len = len[LW-1:0];
    step();
    cmd_valid = 1'b0;
    check_val("busy_accept", 128'(busy), 128'(1));
    check_val("err_cleared", 128'(err_timeout), 128'(0));
    for (int b = 0; b < len; b++) begin
      if (b == bubble_at) begin
        check_val("in_ready_gap", 128'(in_ready), 128'(1));
        step();
      end
      check_val("in_ready_feed", 128'(in_ready), 128'(1));
      in_valid = 1'b1;
      if (fixed) begin
        in_a = {32'd4, 32'd3, 32'd2, 32'd1};
        in_b = {32'd8, 32'd7, 32'd6, 32'd5};
      end else begin
        in_a = {$urandom, $urandom, $urandom, $urandom};
        in_b = {$urandom, $urandom, $urandom, $urandom};
      end
      push_now = 1'b1;
      step();
      push_now = 1'b0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
    end
    check_val("in_ready_after", 128'(in_ready), 128'(0));
    since = 0;
    if (len > 0) begin
      if (mode == 0) begin
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
          cmd_valid = 1'b1;
          cmd_len = 8'($urandom_range(0, 9));
          in_valid = 1'b1;
          in_a = {$urandom, $urandom, $urandom, $urandom};
          en = 4'd0;
          for (int j = 0; j < 4; j++)
            if (col_cnt[j] < 4 && (k >= 30 || $urandom_range(0, 1) == 1)) en[j] = 1'b1;
          pulse(en);
          check_val("cmd_ready_busy", 128'(cmd_ready), 128'(0));
          step();
          since++;
          done = (col_cnt[0] == 4 && col_cnt[1] == 4 && col_cnt[2] == 4 && col_cnt[3] == 4);
        end
        cmd_valid = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
      end else if (mode == 1) begin
        offs = '{0, 0, 1, 2};
        for (int k = 0; k < 12; k++) begin
          en = 4'd0;
          array_data_down = '0;
          for (int j = 0; j < 4; j++) begin
            if ((k - offs[j]) >= 0 && (k - offs[j]) % 3 == 0 && col_cnt[j] < 4) begin
              en[j] = 1'b1;
              array_data_down[j*DW +: DW] = 32'(10 * j + col_cnt[j]);
              exp_buf[col_cnt[j]][j] = 32'(10 * j + col_cnt[j]);
              col_cnt[j]++;
            end
          end
          array_en_down = en;
          step();
          since++;
        end
      end else begin
        pulse(4'hF); step(); since++;
        pulse(4'hF); step(); since++;
        pulse(4'hF); step(); since++;
        pulse(4'h7); step(); since++;
        pulse(4'h1); step(); since++;
      end
      array_en_down = 4'd0;
      array_data_down = '0;
    end
    n = 0;
    while (!res_valid && n < 200) begin
      step();
      since++;
      n++;
    end
    check_val("res_valid_reached", 128'(res_valid), 128'(1));
    tmo = (col_cnt[0] < 4 || col_cnt[1] < 4 || col_cnt[2] < 4 || col_cnt[3] < 4) && (len > 0);
    if (mode == 2) check_val("timeout_window", 128'(since >= 62 && since <= 66), 128'(1));
    check_val("err_timeout_out", 128'(err_timeout), 128'(tmo));
    for (int r = 0; r < 4; r++) begin
      er = {exp_buf[r][3], exp_buf[r][2], exp_buf[r][1], exp_buf[r][0]};
      stall = (mode == 1 && r == 0) ? 3 : $urandom_range(0, 1);
      res_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        check_val("res_hold_valid", 128'(res_valid), 128'(1));
        check_val("res_hold_data", res_data, er);
        step();
      end
      res_ready = 1'b1;
      check_val("res_valid", 128'(res_valid), 128'(1));
      check_val("res_data", res_data, er);
      check_val("res_last", 128'(res_last), 128'(r == 3));
      step();
      res_ready = 1'b0;
    end
    check_val("busy_end", 128'(busy), 128'(0));
    check_val("cmd_ready_end", 128'(cmd_ready), 128'(1));
    check_val("err_timeout_end", 128'(err_timeout), 128'(tmo));
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
    array_en_down = 4'd0; array_data_down = '0; res_ready = 1'b0;
    #3;
    check_val("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    check_val("rst_busy", 128'(busy), 128'(0));
    check_val("rst_in_ready", 128'(in_ready), 128'(0));
    check_val("rst_res_valid", 128'(res_valid), 128'(0));
    check_val("rst_res_last", 128'(res_last), 128'(0));
    check_val("rst_err", 128'(err_timeout), 128'(0));
    check_val("rst_res_data", res_data, 128'(0));
    check_val("rst_en", 128'({array_en_left, array_en_up}), 128'(0));
    step();
    step();
    rst_n = 1'b1;
    step();
    check_val("busy_after_rst", 128'(busy), 128'(0));

    run_job(1, -1, 0, 1'b1);   // skew timing with fixed operands
    run_job(3, 1, 0, 1'b0);    // bubble between beats 1 and 2
    run_job(4, -1, 1, 1'b0);   // pattern collection with backpressure
    run_job(2, -1, 2, 1'b0);   // timeout, extra column-0 pulse
    run_job(0, -1, 0, 1'b0);   // zero length

    // Reset in the middle of FEED.
    cmd_valid = 1'b1; cmd_len = 8'd4;
    step();
    cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      in_valid = 1'b1;
      in_a = {$urandom, $urandom, $urandom, $urandom};
      in_b = {$urandom, $urandom, $urandom, $urandom};
      push_now = 1'b1;
      step();
      push_now = 1'b0;
    end
    in_valid = 1'b0; in_a = '0; in_b = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_en_left", 128'(array_en_left), 128'(0));
    check_val("midrst_en_up", 128'(array_en_up), 128'(0));
    check_val("midrst_busy", 128'(busy), 128'(0));
    check_val("midrst_cmd_ready", 128'(cmd_ready), 128'(1));
    clear_hist();
    step();
    rst_n = 1'b1;
    step();
    check_val("post_rst_busy", 128'(busy), 128'(0));
    run_job(4, -1, 0, 1'b0);

    for (int k = 0; k < 3; k++) run_job($urandom_range(1, 6), $urandom_range(0, 3), 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
